// File: rtl/bht_btb_param_if.sv
// Fetch/execute-side bundle for the branch history table / target buffer.
// master = pipeline side (drives lookup PC and training), slave = predictor.
interface bht_btb_param_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              inv_all;

  modport master (
    output lk_pc, upd_en, upd_pc, upd_taken, upd_target, inv_all,
    input  lk_hit, lk_taken, lk_target
  );

  modport slave (
    input  lk_pc, upd_en, upd_pc, upd_taken, upd_target, inv_all,
    output lk_hit, lk_taken, lk_target
  );
endinterface

// File: rtl/bht_btb_param.sv
// Tagged BHT + BTB: zero-latency lookup, one training update per cycle.
// Define BHT_BYPASS_EN to forward a same-index update into the lookup result.
module bht_btb_param #(
  parameter int IDX_W  = 4,
  parameter int CTR_W  = 2,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bht_btb_param_if.slave   bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] THR     = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] MAX     = '1;
  localparam logic [CTR_W-1:0] RST_CTR = THR - 1'b1;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [CTR_W-1:0]  ctr_q    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              upd_hit;

  logic              upd_valid_d;
  logic [TAG_W-1:0]  upd_tag_d;
  logic [CTR_W-1:0]  upd_ctr_d;
  logic [ADDR_W-1:0] upd_target_d;

  logic              e_valid;
  logic [TAG_W-1:0]  e_tag;
  logic [CTR_W-1:0]  e_ctr;
  logic [ADDR_W-1:0] e_target;
  logic              e_hit;

  // Low PC bits and anything above the tag never take part in addressing.
  logic unused_pc;
  assign unused_pc = ^{bus.lk_pc, bus.upd_pc};

  assign lk_idx  = bus.lk_pc[IDX_W+1:2];
  assign lk_tag  = bus.lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Post-edge contents of the entry addressed by the update port.
  always_comb begin
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_valid_d  = valid_q[upd_idx];
    upd_tag_d    = tag_q[upd_idx];
    upd_ctr_d    = ctr_q[upd_idx];
    upd_target_d = target_q[upd_idx];
    if (upd_hit) begin
      if (bus.upd_taken) begin
        if (ctr_q[upd_idx] != MAX) upd_ctr_d = ctr_q[upd_idx] + 1'b1;
        upd_target_d = bus.upd_target;
      end else if (ctr_q[upd_idx] != '0) begin
        upd_ctr_d = ctr_q[upd_idx] - 1'b1;
      end
    end else if (bus.upd_taken) begin
      upd_valid_d  = 1'b1;
      upd_tag_d    = upd_tag;
      upd_ctr_d    = THR;
      upd_target_d = bus.upd_target;
    end
  end

  always_comb begin
    e_valid  = valid_q[lk_idx];
    e_tag    = tag_q[lk_idx];
    e_ctr    = ctr_q[lk_idx];
    e_target = target_q[lk_idx];
`ifdef BHT_BYPASS_EN
    if (rst_n && bus.upd_en && !bus.inv_all && (upd_idx == lk_idx)) begin
      e_valid  = upd_valid_d;
      e_tag    = upd_tag_d;
      e_ctr    = upd_ctr_d;
      e_target = upd_target_d;
    end
`endif
    e_hit = e_valid && (e_tag == lk_tag);
  end

  assign bus.lk_hit    = e_hit;
  assign bus.lk_taken  = e_hit && (e_ctr >= THR);
  assign bus.lk_target = e_hit ? e_target : '0;

  // inv_all suppresses the whole same-cycle update so the entry ends invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= RST_CTR;
        target_q[i] <= '0;
      end
    end else if (bus.inv_all) begin
      valid_q <= '0;
    end else if (bus.upd_en) begin
      valid_q[upd_idx]  <= upd_valid_d;
      tag_q[upd_idx]    <= upd_tag_d;
      ctr_q[upd_idx]    <= upd_ctr_d;
      target_q[upd_idx] <= upd_target_d;
    end
  end
endmodule

// File: tb/tb_bht_btb_param.sv
// Scoreboard bench for bht_btb_param: directed updates and lookups, checked at negedge.
module tb_bht_btb_param;
  logic clk = 1'b0;
  logic rst_n;

  bht_btb_param_if #(.ADDR_W(32)) bus ();

  bht_btb_param #(.IDX_W(4), .CTR_W(2), .ADDR_W(32), .TAG_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    if (chk_vld) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow: got hit=%0b with no expected entry queued", bus.lk_hit);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.lk_hit !== e.hit || bus.lk_taken !== e.taken || bus.lk_target !== e.target) begin
          bad++;
          $display("FAIL %s: got hit=%0b taken=%0b target=%h, want hit=%0b taken=%0b target=%h",
                   e.name, bus.lk_hit, bus.lk_taken, bus.lk_target, e.hit, e.taken, e.target);
        end
      end
    end
  end

  // Inputs are applied 1ns after posedge, sampled at negedge, consumed at next posedge.
  task automatic step(input logic rn, input logic ue, input logic [31:0] upc,
                      input logic ut, input logic [31:0] utg, input logic inv,
                      input logic [31:0] lpc, input logic chk,
                      input logic eh, input logic et, input logic [31:0] etg,
                      input string name);
    exp_t e;
    rst_n          = rn;
    bus.upd_en     = ue;
    bus.upd_pc     = upc;
    bus.upd_taken  = ut;
    bus.upd_target = utg;
    bus.inv_all    = inv;
    bus.lk_pc      = lpc;
    chk_vld        = chk;
    if (chk) begin
      e.hit = eh; e.taken = et; e.target = etg; e.name = name;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    step(1'b1, 1'b1, pc, t, tgt, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "upd");
  endtask

  task automatic look(input logic [31:0] pc, input logic eh, input logic et,
                      input logic [31:0] etg, input string name);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, pc, 1'b1, eh, et, etg, name);
  endtask

  task automatic reset_cycle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "rst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_cycle();
    reset_cycle();
    look(32'h48, 0, 0, 32'h0, "reset_lk48");
    look(32'h00, 0, 0, 32'h0, "reset_lk00");

    // Same-cycle update and lookup on an empty table.
`ifdef BHT_BYPASS_EN
    step(1, 1, 32'h48, 1, 32'h100, 0, 32'h48, 1, 1, 1, 32'h100, "same_cycle_bypass");
`else
    step(1, 1, 32'h48, 1, 32'h100, 0, 32'h48, 1, 0, 0, 32'h0, "same_cycle_nobypass");
`endif
    look(32'h48, 1, 1, 32'h100, "alloc_ctr2");
    look(32'h4B, 1, 1, 32'h100, "low_bits_ignored");

    upd(32'h48, 0, 32'h0);
    look(32'h48, 1, 0, 32'h100, "nt_ctr1");
    upd(32'h48, 0, 32'h0);
    upd(32'h48, 0, 32'h0);
    look(32'h48, 1, 0, 32'h100, "sat_low_ctr0");
    upd(32'h48, 1, 32'h104);
    look(32'h48, 1, 0, 32'h104, "taken_from0_tgt");
    upd(32'h48, 1, 32'h100);
    look(32'h48, 1, 1, 32'h100, "ctr0_hold_then_2");

    repeat (4) upd(32'h48, 1, 32'h100);
    look(32'h48, 1, 1, 32'h100, "sat_high");
    upd(32'h48, 0, 32'h0);
    look(32'h48, 1, 1, 32'h100, "from_max_ctr2");
    upd(32'h48, 0, 32'h0);
    look(32'h48, 1, 0, 32'h100, "from_max_ctr1");

    // Aliasing: 0x448 shares index 2 with tag 0x11.
    upd(32'h448, 1, 32'h200);
    look(32'h48,  0, 0, 32'h0,   "alias_evicted");
    look(32'h448, 1, 1, 32'h200, "alias_alloc");
    upd(32'h848, 0, 32'h0);
    look(32'h448, 1, 1, 32'h200, "nt_miss_nochange");
    look(32'h848, 0, 0, 32'h0,   "nt_miss_noalloc");
    upd(32'h448, 0, 32'h0);
    look(32'h448, 1, 0, 32'h200, "alias_dec");

    upd(32'h10, 1, 32'h300);
    look(32'h10,  1, 1, 32'h300, "idx4_alloc");
    look(32'h448, 1, 0, 32'h200, "idx2_independent");

    step(1, 1, 32'h48, 1, 32'h500, 1, 32'h0, 0, 0, 0, 32'h0, "inv_upd");
    look(32'h48,  0, 0, 32'h0, "inv_lk48");
    look(32'h448, 0, 0, 32'h0, "inv_lk448");
    look(32'h10,  0, 0, 32'h0, "inv_lk10");

    upd(32'h10, 1, 32'h300);
    look(32'h10, 1, 1, 32'h300, "realloc_after_inv");
    step(0, 1, 32'h10, 1, 32'h999, 0, 32'h0, 0, 0, 0, 32'h0, "rst_mid");
    look(32'h10,  0, 0, 32'h0, "rst_mid_lk10");
    look(32'h448, 0, 0, 32'h0, "rst_mid_lk448");

    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, "drain");
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: %0d entries unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
